// File: rtl/tdc_scan_sequencer.sv
// rtl/tdc_scan_sequencer.sv - scans NCH timestatics channels: start, acquire, drain FIFO to a tagged stream
module tdc_scan_sequencer #(
    parameter int          NCH        = 4,
    parameter logic [7:0]  BASEAD     = 8'hC4,
    parameter int          ACQ_CYCLES = 1024,
    parameter int          MAXWORDS   = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            go_i,
    input  logic            abort_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [NCH-1:0]  ch_start_o,
    input  logic [NCH-1:0]  ch_empty_i,
    output logic [7:0]      address_o,
    output logic            read_o,
    input  logic [31:0]     data_in_i,
    output logic [31:0]     out_data_o,
    output logic [3:0]      out_ch_o,
    output logic            out_valid_o,
    input  logic            out_ready_i
);

    localparam int AW = (ACQ_CYCLES > 1) ? $clog2(ACQ_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ACQ,
        S_RDADDR,
        S_RDHOLD,
        S_PUSH,
        S_GAP,
        S_NEXT,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      ch_q, ch_d;
    logic [6:0]      wcnt_q, wcnt_d;
    logic [AW-1:0]   acq_q, acq_d;
    logic [31:0]     out_data_q, out_data_d;
    logic [3:0]      out_ch_q, out_ch_d;

    logic [15:0]     empty_ext;
    logic [7:0]      chan_addr;

    assign empty_ext = 16'(ch_empty_i);
    assign chan_addr = BASEAD + {4'd0, ch_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            wcnt_q     <= '0;
            acq_q      <= '0;
            out_data_q <= '0;
            out_ch_q   <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            wcnt_q     <= wcnt_d;
            acq_q      <= acq_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
        end
    end

    // All bus/handshake outputs decode from state so an async reset clears them at once.
    always_comb begin
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        ch_start_o  = (state_q == S_START) ? NCH'(16'd1 << ch_q) : '0;
        read_o      = (state_q == S_RDADDR) || (state_q == S_RDHOLD);
        address_o   = ((state_q == S_RDADDR) || (state_q == S_RDHOLD) || (state_q == S_PUSH))
                      ? chan_addr : 8'd0;
        out_valid_o = (state_q == S_PUSH);
        out_data_o  = out_data_q;
        out_ch_o    = out_ch_q;
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        wcnt_d     = wcnt_q;
        acq_d      = acq_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;

        case (state_q)
            S_IDLE: begin
                if (go_i && !abort_i) begin
                    ch_d    = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                acq_d   = AW'(ACQ_CYCLES - 1);
                state_d = S_ACQ;
            end
            S_ACQ: begin
                if (acq_q == '0) begin
                    state_d = S_RDADDR;
                end else begin
                    acq_d = acq_q - 1'b1;
                end
            end
            S_RDADDR: begin
                state_d = empty_ext[ch_q] ? S_NEXT : S_RDHOLD;
            end
            S_RDHOLD: begin
                out_data_d = data_in_i;
                out_ch_d   = ch_q;
                wcnt_d     = wcnt_q + 1'b1;
                state_d    = S_PUSH;
            end
            S_PUSH: begin
                if (out_ready_i) begin
                    state_d = (wcnt_q == 7'(MAXWORDS)) ? S_NEXT : S_GAP;
                end
            end
            // Idle bus cycle re-arms the channel's read block before the next word.
            S_GAP: begin
                state_d = S_RDADDR;
            end
            S_NEXT: begin
                wcnt_d = '0;
                if (ch_q == 4'(NCH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = S_START;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            ch_d    = '0;
            wcnt_d  = '0;
        end
    end

endmodule

// File: tb/tb_tdc_scan_sequencer.sv
// tb/tb_tdc_scan_sequencer.sv - directed vector bench for tdc_scan_sequencer
module tb_tdc_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, go, abort, oready;
    logic        busy, done, read, ovalid;
    logic [1:0]  cs, ch_empty;
    logic [7:0]  addr;
    logic [31:0] din, odata;
    logic [3:0]  och;

    logic        go_b, oready_b, busy_b, done_b, read_b, ovalid_b;
    logic [1:0]  cs_b, ch_empty_b;
    logic [7:0]  addr_b;
    logic [31:0] din_b, odata_b;
    logic [3:0]  och_b;

    tdc_scan_sequencer #(.NCH(2), .BASEAD(8'hC4), .ACQ_CYCLES(4), .MAXWORDS(4)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .go_i(go), .abort_i(abort),
        .busy_o(busy), .done_o(done), .ch_start_o(cs), .ch_empty_i(ch_empty),
        .address_o(addr), .read_o(read), .data_in_i(din),
        .out_data_o(odata), .out_ch_o(och), .out_valid_o(ovalid), .out_ready_i(oready)
    );

    tdc_scan_sequencer #(.NCH(2), .BASEAD(8'hC4), .ACQ_CYCLES(4), .MAXWORDS(2)) u_trunc (
        .clk_i(clk), .rst_ni(rst_n), .go_i(go_b), .abort_i(abort),
        .busy_o(busy_b), .done_o(done_b), .ch_start_o(cs_b), .ch_empty_i(ch_empty_b),
        .address_o(addr_b), .read_o(read_b), .data_in_i(din_b),
        .out_data_o(odata_b), .out_ch_o(och_b), .out_valid_o(ovalid_b), .out_ready_i(oready_b)
    );

    // Channel 0 FIFO model: load0 words, one popped per accepted transfer; channel 1 always empty.
    logic [31:0] words [3] = '{32'h0003_0011, 32'h0002_0022, 32'h0001_0033};
    int n_xfer = 0;
    int base   = 0;
    int load0  = 0;
    int widx;
    assign widx     = n_xfer - base;
    assign ch_empty = {1'b1, (widx >= load0)};
    assign din      = (read && addr == 8'hC4 && widx < 3) ? words[widx[1:0]] : 32'h0;
    assign ch_empty_b = 2'b00;
    assign din_b      = 32'hA5A5_0000;
    assign oready_b   = 1'b1;

    int          cyc = 0, run = 0, n_done = 0, nb_done = 0, cs1_cyc = -1, cs1b_cyc = -1;
    logic [7:0]  raddr = 8'h0;
    logic [31:0] xd[$];
    logic [3:0]  xc[$];
    int          xt[$];
    int          runs[$];
    logic [7:0]  raddrs[$];
    logic [3:0]  bch[$];
    int          bt[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ovalid && oready) begin
            n_xfer <= n_xfer + 1;
            xd.push_back(odata);
            xc.push_back(och);
            xt.push_back(cyc);
        end
        if (read) begin
            run   <= run + 1;
            raddr <= addr;
        end else if (run > 0) begin
            runs.push_back(run);
            raddrs.push_back(raddr);
            run <= 0;
        end
        if (done) n_done <= n_done + 1;
        if (cs[1]) cs1_cyc <= cyc;
        if (ovalid_b && oready_b) begin
            bch.push_back(och_b);
            bt.push_back(cyc);
        end
        if (cs_b[1] && cs1b_cyc < 0) cs1b_cyc <= cyc;
        if (done_b) nb_done <= nb_done + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic        go;
        logic        abort;
        logic [13:0] exp;
    } vec_t;

    function automatic vec_t mkv(logic g, logic a, logic b, logic [1:0] c, logic [7:0] ad,
                                 logic r, logic d);
        return '{g, a, {b, c, ad, r, d, 1'b0}};
    endfunction

    vec_t vecs [18];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0, x0, r0, xs;
        bit ok;

        // Empty-FIFO scan, one vector per cycle; go during ACQ and NEXT must be ignored.
        vecs[0]  = mkv(1, 1, 0, 2'b00, 8'h00, 0, 0);
        vecs[1]  = mkv(1, 0, 1, 2'b01, 8'h00, 0, 0);
        vecs[2]  = mkv(0, 0, 1, 2'b00, 8'h00, 0, 0);
        vecs[3]  = mkv(1, 0, 1, 2'b00, 8'h00, 0, 0);
        vecs[4]  = mkv(0, 0, 1, 2'b00, 8'h00, 0, 0);
        vecs[5]  = mkv(0, 0, 1, 2'b00, 8'h00, 0, 0);
        vecs[6]  = mkv(0, 0, 1, 2'b00, 8'hC4, 1, 0);
        vecs[7]  = mkv(0, 0, 1, 2'b00, 8'h00, 0, 0);
        vecs[8]  = mkv(0, 0, 1, 2'b10, 8'h00, 0, 0);
        vecs[9]  = mkv(0, 0, 1, 2'b00, 8'h00, 0, 0);
        vecs[10] = mkv(0, 0, 1, 2'b00, 8'h00, 0, 0);
        vecs[11] = mkv(0, 0, 1, 2'b00, 8'h00, 0, 0);
        vecs[12] = mkv(0, 0, 1, 2'b00, 8'h00, 0, 0);
        vecs[13] = mkv(0, 0, 1, 2'b00, 8'hC5, 1, 0);
        vecs[14] = mkv(1, 0, 1, 2'b00, 8'h00, 0, 0);
        vecs[15] = mkv(0, 0, 1, 2'b00, 8'h00, 0, 1);
        vecs[16] = mkv(0, 0, 0, 2'b00, 8'h00, 0, 0);
        vecs[17] = mkv(0, 1, 0, 2'b00, 8'h00, 0, 0);

        rst_n = 1'b0; go = 1'b0; abort = 1'b0; oready = 1'b1; go_b = 1'b0;
        #12;
        check("reset_outputs", 64'({busy, done, cs, addr, read, ovalid, och}), 64'h0);
        check("reset_out_data", 64'(odata), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        d0 = n_done;
        x0 = xd.size();
        for (int k = 0; k < 18; k++) begin
            go    = vecs[k].go;
            abort = vecs[k].abort;
            tick();
            check($sformatf("vec%0d", k), 64'({busy, cs, addr, read, done, ovalid}), 64'(vecs[k].exp));
        end
        go = 1'b0; abort = 1'b0;
        check("empty_scan_done_count", 64'(n_done - d0), 64'd1);
        check("empty_scan_no_words", 64'(xd.size() - x0), 64'd0);

        // Channel 0 holds three words, consumer always ready.
        base = n_xfer; load0 = 3;
        r0 = runs.size(); x0 = xd.size(); d0 = n_done;
        go = 1'b1; tick(); go = 1'b0;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (n_done > d0) begin ok = 1; break; end
        end
        check("scan3_done_seen", 64'(ok), 64'd1);
        tick();
        check("scan3_word_count", 64'(xd.size() - x0), 64'd3);
        if (xd.size() - x0 == 3) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("scan3_data%0d", k), 64'(xd[x0+k]), 64'(words[k]));
                check($sformatf("scan3_ch%0d", k), 64'(xc[x0+k]), 64'd0);
                if (k > 0) check($sformatf("scan3_spacing%0d", k), 64'(xt[x0+k] - xt[x0+k-1]), 64'd4);
            end
            check("scan3_ch1_start_after", 64'(cs1_cyc - xt[x0+2]), 64'd4);
        end
        check("scan3_read_runs", 64'(runs.size() - r0), 64'd5);
        if (runs.size() - r0 == 5) begin
            check("scan3_run_lengths", 64'({runs[r0][3:0], runs[r0+1][3:0], runs[r0+2][3:0],
                                           runs[r0+3][3:0], runs[r0+4][3:0]}), 64'h22211);
            check("scan3_run_addrs", 64'({raddrs[r0], raddrs[r0+1], raddrs[r0+2],
                                         raddrs[r0+3], raddrs[r0+4]}), 64'hC4C4C4C4C5);
        end

        // Backpressure: ready low for 10 PUSH cycles.
        base = n_xfer; load0 = 1; oready = 1'b0;
        go = 1'b1; tick(); go = 1'b0;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (ovalid) begin ok = 1; break; end
        end
        check("bp_valid_seen", 64'(ok), 64'd1);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("bp_hold%0d", k), 64'({ovalid, read, och, odata}), 64'({1'b1, 1'b0, 4'd0, words[0]}));
            tick();
        end
        xs = xd.size();
        oready = 1'b1;
        tick();
        check("bp_transfer_first_ready", 64'({ovalid, 4'(xd.size() - xs)}), 64'h01);
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (!busy) begin ok = 1; break; end
        end
        check("bp_scan_ends", 64'(ok), 64'd1);

        // Abort during ACQ.
        d0 = n_done;
        go = 1'b1; tick(); go = 1'b0;
        tick(); tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_acq_outputs", 64'({read, ovalid, busy, done, cs, addr}), 64'h0);
        for (int k = 0; k < 20; k++) tick();
        check("abort_acq_no_done", 64'({busy, 8'(n_done - d0)}), 64'h0);

        // Restart after abort, then abort with a word pending in PUSH.
        base = n_xfer; load0 = 1; oready = 1'b0;
        go = 1'b1; tick(); go = 1'b0;
        check("restart_ch0", 64'({busy, cs}), 64'h5);
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (ovalid) begin ok = 1; break; end
        end
        check("abort_push_valid_seen", 64'(ok), 64'd1);
        xs = xd.size();
        abort = 1'b1; tick(); abort = 1'b0;
        oready = 1'b1;
        check("abort_push_outputs", 64'({read, ovalid, busy, done, cs, addr}), 64'h0);
        for (int k = 0; k < 10; k++) tick();
        check("abort_push_dropped", 64'({8'(n_done - d0), 8'(xd.size() - xs)}), 64'h0);
        go = 1'b1; tick(); go = 1'b0;
        check("restart2_ch0", 64'({busy, cs}), 64'h5);
        abort = 1'b1; tick(); abort = 1'b0;

        // Asynchronous reset during RDHOLD.
        base = n_xfer; load0 = 3; oready = 1'b1;
        go = 1'b1; tick(); go = 1'b0;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (read) begin ok = 1; break; end
        end
        check("rst_read_seen", 64'(ok), 64'd1);
        tick();
        check("rst_in_rdhold", 64'({read, addr}), 64'h1C4);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_drop", 64'({read, busy, addr, ovalid}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_not_resumed", 64'({busy, read}), 64'h0);

        // Truncation at MAXWORDS=2 with channels never empty.
        go_b = 1'b1; tick(); go_b = 1'b0;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (nb_done > 0) begin ok = 1; break; end
        end
        check("trunc_done_seen", 64'(ok), 64'd1);
        check("trunc_total_words", 64'(bch.size()), 64'd4);
        if (bch.size() == 4) begin
            check("trunc_chs", 64'({bch[0], bch[1], bch[2], bch[3]}), 64'h0011);
            check("trunc_ch1_start_gap", 64'(cs1b_cyc - bt[1]), 64'd2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
